// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: Moore FSM that sequences the memory-game datapath.
// It presents the stored sequence, collects and compares player moves, and in
// modo 2 records a new move after every completed round.
// Optional feature macro: TIMEOUT_EN. When it is defined, player inactivity ends
// the game. When it is not defined, the timeout input is ignored and
// zera_to/conta_to stay at 0.
module unidade_controle_jogo #(
    parameter int ESTADO_W = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                modo2,
    input  logic                jogada_feita,
    input  logic                jogada_correta,
    input  logic                endereco_igual_rodada,
    input  logic                rodada_final,
    input  logic                fim_tm,
    input  logic                fim_intervalo,
    input  logic                timeout,
    output logic                zera_e,
    output logic                conta_e,
    output logic                zera_r,
    output logic                conta_r,
    output logic                zera_tm,
    output logic                conta_tm,
    output logic                zera_to,
    output logic                conta_to,
    output logic                registra_cfg,
    output logic                registra_jogada,
    output logic                grava_m,
    output logic                mostra_leds,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                vez_jogador,
    output logic                nova_jogada,
    output logic [ESTADO_W-1:0] db_estado
);

    typedef enum logic [4:0] {
        INICIAL       = 5'h00,
        PREPARACAO    = 5'h01,
        INICIA_RODADA = 5'h02,
        APRESENTA     = 5'h03,
        INTERVALO     = 5'h04,
        PROX_APRES    = 5'h05,
        ESPERA        = 5'h06,
        REGISTRA      = 5'h07,
        COMPARA       = 5'h08,
        PROX_JOGADA   = 5'h09,
        GRAVA_FIM     = 5'h0A,
        PROX_RODADA   = 5'h0B,
        ESPERA_GRAVA  = 5'h0C,
        GRAVA         = 5'h0D,
        FIM_ACERTOU   = 5'h0E,
        FIM_ERROU     = 5'h0F,
        FIM_TIMEOUT   = 5'h10
    } estado_t;

    typedef struct packed {
        logic zera_e;
        logic conta_e;
        logic zera_r;
        logic conta_r;
        logic zera_tm;
        logic conta_tm;
        logic zera_to;
        logic conta_to;
        logic registra_cfg;
        logic registra_jogada;
        logic grava_m;
        logic mostra_leds;
        logic pronto;
        logic ganhou;
        logic perdeu;
        logic vez_jogador;
        logic nova_jogada;
    } saida_t;

    estado_t estado, prox;
    saida_t  saida;
    logic    modo2_reg;   // mode latched in preparacao
    logic    rodada_nz;   // round counter has left 0 since the last start
    logic    timeout_ativo;

`ifdef TIMEOUT_EN
    assign timeout_ativo = timeout;
`else
    assign timeout_ativo = 1'b0;
    logic unused_timeout;
    assign unused_timeout = timeout;
`endif

    // Outputs for a given state. Prox_apres is the only state whose outputs
    // depend on an input. That input is endereco_igual_rodada, sampled on entry.
    // The address counter does not move between intervalo and prox_apres, so the
    // sampled value matches the value the transition out of prox_apres uses.
    function automatic saida_t decodifica(estado_t s, logic eir);
        saida_t o;
        o = '0;
        case (s)
            PREPARACAO: begin
                o.registra_cfg = 1'b1;
                o.zera_e       = 1'b1;
                o.zera_r       = 1'b1;
                o.zera_tm      = 1'b1;
`ifdef TIMEOUT_EN
                o.zera_to      = 1'b1;
`endif
            end
            INICIA_RODADA: begin
                o.zera_e  = 1'b1;
                o.zera_tm = 1'b1;
            end
            APRESENTA: begin
                o.mostra_leds = 1'b1;
                o.conta_tm    = 1'b1;
            end
            INTERVALO: o.conta_tm = 1'b1;
            PROX_APRES: begin
                if (eir) begin
                    o.zera_e  = 1'b1;
                end else begin
                    o.conta_e = 1'b1;
                    o.zera_tm = 1'b1;
                end
            end
            ESPERA: begin
                o.vez_jogador = 1'b1;
`ifdef TIMEOUT_EN
                o.conta_to    = 1'b1;
`endif
            end
            REGISTRA: begin
                o.registra_jogada = 1'b1;
`ifdef TIMEOUT_EN
                o.zera_to         = 1'b1;
`endif
            end
            PROX_JOGADA: o.conta_e = 1'b1;
            PROX_RODADA: begin
                o.conta_r = 1'b1;
                o.conta_e = 1'b1;
            end
            ESPERA_GRAVA: begin
                o.nova_jogada = 1'b1;
`ifdef TIMEOUT_EN
                o.conta_to    = 1'b1;
`endif
            end
            GRAVA: o.registra_jogada = 1'b1;
            GRAVA_FIM: begin
                o.grava_m = 1'b1;
`ifdef TIMEOUT_EN
                o.zera_to = 1'b1;
`endif
            end
            FIM_ACERTOU: begin
                o.pronto = 1'b1;
                o.ganhou = 1'b1;
            end
            FIM_ERROU, FIM_TIMEOUT: begin
                o.pronto = 1'b1;
                o.perdeu = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Next-state selection. A move takes priority over timeout in the wait states.
    always_comb begin
        prox = INICIAL;
        case (estado)
            INICIAL:       prox = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:    prox = INICIA_RODADA;
            INICIA_RODADA: prox = (modo2_reg && rodada_nz) ? ESPERA : APRESENTA;
            APRESENTA:     prox = fim_tm ? INTERVALO : APRESENTA;
            INTERVALO:     prox = fim_intervalo ? PROX_APRES : INTERVALO;
            PROX_APRES:    prox = endereco_igual_rodada ? ESPERA : APRESENTA;
            ESPERA: begin
                if (jogada_feita)       prox = REGISTRA;
                else if (timeout_ativo) prox = FIM_TIMEOUT;
                else                    prox = ESPERA;
            end
            REGISTRA:      prox = COMPARA;
            COMPARA: begin
                if (!jogada_correta)             prox = FIM_ERROU;
                else if (!endereco_igual_rodada) prox = PROX_JOGADA;
                else if (rodada_final)           prox = FIM_ACERTOU;
                else                             prox = PROX_RODADA;
            end
            PROX_JOGADA:   prox = ESPERA;
            PROX_RODADA:   prox = modo2_reg ? ESPERA_GRAVA : INICIA_RODADA;
            ESPERA_GRAVA: begin
                if (jogada_feita)       prox = GRAVA;
                else if (timeout_ativo) prox = FIM_TIMEOUT;
                else                    prox = ESPERA_GRAVA;
            end
            GRAVA:         prox = GRAVA_FIM;
            GRAVA_FIM:     prox = INICIA_RODADA;
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                           prox = iniciar ? PREPARACAO : estado;
            default:       prox = INICIAL;
        endcase
    end

    // State, registered Moore outputs, and game-mode bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= INICIAL;
            saida     <= '0;
            modo2_reg <= 1'b0;
            rodada_nz <= 1'b0;
        end else begin
            estado <= prox;
            saida  <= decodifica(prox, endereco_igual_rodada);
            if (estado == PREPARACAO) begin
                modo2_reg <= modo2;
                rodada_nz <= 1'b0;
            end
            if (estado == PROX_RODADA)
                rodada_nz <= 1'b1;
        end
    end

    assign zera_e          = saida.zera_e;
    assign conta_e         = saida.conta_e;
    assign zera_r          = saida.zera_r;
    assign conta_r         = saida.conta_r;
    assign zera_tm         = saida.zera_tm;
    assign conta_tm        = saida.conta_tm;
    assign zera_to         = saida.zera_to;
    assign conta_to        = saida.conta_to;
    assign registra_cfg    = saida.registra_cfg;
    assign registra_jogada = saida.registra_jogada;
    assign grava_m         = saida.grava_m;
    assign mostra_leds     = saida.mostra_leds;
    assign pronto          = saida.pronto;
    assign ganhou          = saida.ganhou;
    assign perdeu          = saida.perdeu;
    assign vez_jogador     = saida.vez_jogador;
    assign nova_jogada     = saida.nova_jogada;
    assign db_estado       = ESTADO_W'(estado);

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Testbench for unidade_controle_jogo. It applies a table of single-cycle
// vectors, then runs hand-written multi-cycle scenarios against a small
// address/round counter model.
module tb_unidade_controle_jogo;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic iniciar = 1'b0, modo2 = 1'b0, jogada_feita = 1'b0, jogada_correta = 1'b0;
    logic fim_tm = 1'b0, fim_intervalo = 1'b0, timeout = 1'b0;
    logic endereco_igual_rodada, rodada_final;
    logic zera_e, conta_e, zera_r, conta_r, zera_tm, conta_tm, zera_to, conta_to;
    logic registra_cfg, registra_jogada, grava_m, mostra_leds;
    logic pronto, ganhou, perdeu, vez_jogador, nova_jogada;
    logic [4:0] db_estado;

    // Datapath stand-in: direct drive in the table, counter model in the sequences.
    logic       use_model = 1'b0;
    logic       eir_v = 1'b0, rf_v = 1'b0;
    logic [3:0] e_cnt = '0, r_cnt = '0, last_r = 4'd3;
    assign endereco_igual_rodada = use_model ? (e_cnt == r_cnt) : eir_v;
    assign rodada_final          = use_model ? (r_cnt == last_r) : rf_v;

    always @(posedge clock) begin
        if (zera_e) e_cnt <= '0; else if (conta_e) e_cnt <= e_cnt + 4'd1;
        if (zera_r) r_cnt <= '0; else if (conta_r) r_cnt <= r_cnt + 4'd1;
    end

    unidade_controle_jogo #(.ESTADO_W(5)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .modo2(modo2),
        .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
        .endereco_igual_rodada(endereco_igual_rodada), .rodada_final(rodada_final),
        .fim_tm(fim_tm), .fim_intervalo(fim_intervalo), .timeout(timeout),
        .zera_e(zera_e), .conta_e(conta_e), .zera_r(zera_r), .conta_r(conta_r),
        .zera_tm(zera_tm), .conta_tm(conta_tm), .zera_to(zera_to), .conta_to(conta_to),
        .registra_cfg(registra_cfg), .registra_jogada(registra_jogada),
        .grava_m(grava_m), .mostra_leds(mostra_leds), .pronto(pronto),
        .ganhou(ganhou), .perdeu(perdeu), .vez_jogador(vez_jogador),
        .nova_jogada(nova_jogada), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Output bit positions in the observed vector.
    localparam logic [16:0] ZE  = 17'h10000, CE  = 17'h08000, ZR  = 17'h04000, CR  = 17'h02000;
    localparam logic [16:0] ZTM = 17'h01000, CTM = 17'h00800, ZTO = 17'h00400, CTO = 17'h00200;
    localparam logic [16:0] CFG = 17'h00100, RJ  = 17'h00080, GM  = 17'h00040, ML  = 17'h00020;
    localparam logic [16:0] PR  = 17'h00010, GA  = 17'h00008, PE  = 17'h00004, VJ  = 17'h00002;
    localparam logic [16:0] NJ  = 17'h00001;
`ifdef TIMEOUT_EN
    localparam logic [16:0] TOM = 17'h1ffff;
`else
    localparam logic [16:0] TOM = ~(ZTO | CTO);
`endif

    // Input bits: {iniciar, modo2, jf, jc, eir, rf, fim_tm, fim_int, timeout}
    localparam logic [8:0] I_INI = 9'h100, I_M2 = 9'h080, I_JF = 9'h040, I_JC = 9'h020;
    localparam logic [8:0] I_EIR = 9'h010, I_RF = 9'h008, I_FTM = 9'h004, I_FIN = 9'h002;
    localparam logic [8:0] I_TO  = 9'h001;

    logic [16:0] outs;
    assign outs = {zera_e, conta_e, zera_r, conta_r, zera_tm, conta_tm, zera_to, conta_to,
                   registra_cfg, registra_jogada, grava_m, mostra_leds,
                   pronto, ganhou, perdeu, vez_jogador, nova_jogada};

    typedef struct {
        logic [8:0]  in;
        logic [4:0]  st;
        logic [16:0] out;
    } vec_t;

    localparam int NV = 31;
    vec_t vt [NV];

    int n_vec  = 0;
    int n_fail = 0;
    int n_apres = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        {iniciar, modo2, jogada_feita, jogada_correta, fim_tm, fim_intervalo, timeout} = '0;
        use_model = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Steps until db_estado reaches tgt. In auto mode it pulses jogada_feita
    // whenever the player is being waited on. It also counts presentation cycles.
    task automatic run_until(input logic [4:0] tgt, input int budget, input bit auto_jf,
                             output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (db_estado == tgt) begin
                ok = 1'b1;
                break;
            end
            jogada_feita = auto_jf && (db_estado == 5'h06);
            step();
            if (db_estado == 5'h03) n_apres++;
        end
        jogada_feita = 1'b0;
    endtask

    task automatic start(input logic m2);
        modo2   = m2;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
    endtask

    initial begin
        bit ok;

        vt[0]  = '{9'h000,                5'h00, 17'h0};
        vt[1]  = '{I_INI,                 5'h01, CFG | ZE | ZR | ZTM | ZTO};
        vt[2]  = '{I_INI,                 5'h02, ZE | ZTM};
        vt[3]  = '{9'h000,                5'h03, ML | CTM};
        vt[4]  = '{I_JF,                  5'h03, ML | CTM};
        vt[5]  = '{I_FTM,                 5'h04, CTM};
        vt[6]  = '{9'h000,                5'h04, CTM};
        vt[7]  = '{I_FIN | I_EIR,         5'h05, ZE};
        vt[8]  = '{I_EIR,                 5'h06, VJ | CTO};
        vt[9]  = '{9'h000,                5'h06, VJ | CTO};
        vt[10] = '{I_JF | I_TO,           5'h07, RJ | ZTO};
        vt[11] = '{9'h000,                5'h08, 17'h0};
        vt[12] = '{I_EIR,                 5'h0F, PR | PE};
        vt[13] = '{9'h000,                5'h0F, PR | PE};
        vt[14] = '{I_INI,                 5'h01, CFG | ZE | ZR | ZTM | ZTO};
        vt[15] = '{9'h000,                5'h02, ZE | ZTM};
        vt[16] = '{9'h000,                5'h03, ML | CTM};
        vt[17] = '{I_FTM,                 5'h04, CTM};
        vt[18] = '{I_FIN,                 5'h05, CE | ZTM};
        vt[19] = '{9'h000,                5'h03, ML | CTM};
        vt[20] = '{I_FTM,                 5'h04, CTM};
        vt[21] = '{I_FIN | I_EIR,         5'h05, ZE};
        vt[22] = '{I_EIR,                 5'h06, VJ | CTO};
        vt[23] = '{I_JF,                  5'h07, RJ | ZTO};
        vt[24] = '{9'h000,                5'h08, 17'h0};
        vt[25] = '{I_JC,                  5'h09, CE};
        vt[26] = '{9'h000,                5'h06, VJ | CTO};
        vt[27] = '{I_JF,                  5'h07, RJ | ZTO};
        vt[28] = '{9'h000,                5'h08, 17'h0};
        vt[29] = '{I_JC | I_EIR | I_RF,   5'h0E, PR | GA};
        vt[30] = '{9'h000,                5'h0E, PR | GA};

        // Reset state, checked while reset is held and after release.
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", db_estado, 5'h00);
        chk("reset_outs", outs, 17'h0);
        reset = 1'b1;
        step();
        chk("post_reset_state", db_estado, 5'h00);

        // Table-driven single-cycle vectors.
        for (int i = 0; i < NV; i++) begin
            {iniciar, modo2, jogada_feita, jogada_correta, eir_v, rf_v,
             fim_tm, fim_intervalo, timeout} = vt[i].in;
            step();
            chk($sformatf("vec%0d_state", i), db_estado, vt[i].st);
            chk($sformatf("vec%0d_outs", i), outs, vt[i].out & TOM);
        end

        // Modo 1, four rounds, all correct: 1+2+3+4 presentations, then a win.
        do_reset();
        start(1'b0);
        use_model = 1'b1;
        last_r = 4'd3;
        fim_tm = 1'b1; fim_intervalo = 1'b1; jogada_correta = 1'b1;
        n_apres = 0;
        run_until(5'h0E, 400, 1'b1, ok);
        chk("win_reached", ok, 1'b1);
        chk("win_presentations", n_apres, 10);
        chk("win_outs", outs, PR | GA);

        // Modo 2: record a new move after round 0, and skip the presentation next round.
        do_reset();
        start(1'b1);
        use_model = 1'b1;
        last_r = 4'd15;
        fim_tm = 1'b1; fim_intervalo = 1'b1; jogada_correta = 1'b1;
        run_until(5'h0C, 100, 1'b1, ok);
        chk("m2_reach_0C", ok, 1'b1);
        chk("m2_0C_outs", outs, (NJ | CTO) & TOM);
        jogada_feita = 1'b1;
        step();
        jogada_feita = 1'b0;
        chk("m2_0D_state", db_estado, 5'h0D);
        chk("m2_0D_outs", outs, RJ);
        step();
        chk("m2_0A_state", db_estado, 5'h0A);
        chk("m2_0A_outs", outs, (GM | ZTO) & TOM);
        step();
        chk("m2_02_state", db_estado, 5'h02);
        step();
        chk("m2_skip_present", db_estado, 5'h06);
        chk("m2_06_outs", outs, (VJ | CTO) & TOM);

        // Timeout while waiting for the player.
        do_reset();
        start(1'b0);
        use_model = 1'b1;
        fim_tm = 1'b1; fim_intervalo = 1'b1;
        run_until(5'h06, 50, 1'b0, ok);
        chk("to_reach_06", ok, 1'b1);
        timeout = 1'b1;
        step();
        step();
        timeout = 1'b0;
`ifdef TIMEOUT_EN
        chk("to_state", db_estado, 5'h10);
        chk("to_outs", outs, PR | PE);
        jogada_feita = 1'b1;
        step();
        jogada_feita = 1'b0;
        chk("to_hold", db_estado, 5'h10);
`else
        chk("to_ignored_state", db_estado, 5'h06);
        chk("to_ignored_outs", outs, VJ);
`endif

        // Asynchronous reset in the middle of the presentation, then a fresh start.
        do_reset();
        start(1'b0);
        use_model = 1'b1;
        fim_tm = 1'b1; fim_intervalo = 1'b0;
        run_until(5'h04, 50, 1'b0, ok);
        chk("rst_reach_04", ok, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state", db_estado, 5'h00);
        chk("async_rst_outs", outs, 17'h0);
        step();
        reset = 1'b1;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("restart_01", db_estado, 5'h01);
        step();
        chk("restart_02", db_estado, 5'h02);
        step();
        chk("restart_03", db_estado, 5'h03);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
